matrix_buffer_responder: RTL and testbench

Memory responder on the far side of the matrix multiplier's A/B/C memory ports. It holds three single-clock RAMs: A and B are read-only to the multiplier, and C is write-only from it.
- A and B answer the multiplier's read_en/addr requests with fixed 1-cycle latency.
- C absorbs the multiplier's write_en/addr/data writes.
- A host-side streaming interface (valid/ready) loads A/B and unloads C, with a skid-buffered output path.

---
 rtl/matrix_buffer_responder.sv | 163 ++++++++++++++++
 tb/tb_matrix_buffer_responder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_buffer_responder.sv
// rtl/matrix_buffer_responder.sv - A/B/C memory responder for the matrix multiplier
// Host streams load A/B and unload C; the multiplier reads A/B and writes C.
module matrix_buffer_responder #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  output logic                  cmd_err,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic [ADDR_WIDTH-1:0] mm_addr_a,
  input  logic                  mm_read_en_a,
  output logic [DATA_WIDTH-1:0] mm_data_a,
  input  logic [ADDR_WIDTH-1:0] mm_addr_b,
  input  logic                  mm_read_en_b,
  output logic [DATA_WIDTH-1:0] mm_data_b,
  input  logic [ADDR_WIDTH-1:0] mm_addr_c,
  input  logic [DATA_WIDTH-1:0] mm_data_c,
  input  logic                  mm_write_en_c,
  output logic [ADDR_WIDTH:0]   c_wr_count,
  output logic                  conflict_err
);
  localparam int                WORDS   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] LEN_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, UNLOAD} state_t;
  state_t state;

  logic [DATA_WIDTH-1:0] ram_a [WORDS];
  logic [DATA_WIDTH-1:0] ram_b [WORDS];
  logic [DATA_WIDTH-1:0] ram_c [WORDS];

  logic [ADDR_WIDTH:0]   len, ptr;
  logic                  q_vld, q_last;
  logic [DATA_WIDTH-1:0] q_data;
  logic [DATA_WIDTH-1:0] buf_data [2];
  logic [1:0]            buf_last;
  logic [1:0]            buf_cnt, wr_idx;
  logic [2:0]            occ;
  logic                  cmd_fire, len_ok, in_beat, pop, issue, ptr_at_end, clear;

  assign cmd_ready  = (state == IDLE);
  assign in_ready   = (state == LOAD_A) || (state == LOAD_B);
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign len_ok     = (cmd_len != '0) && (cmd_len <= DEPTH);
  assign in_beat    = in_valid && in_ready;
  assign clear      = cmd_fire && (cmd_op == 2'b11);
  assign ptr_at_end = (ptr == len - LEN_ONE);

  assign out_valid = (buf_cnt != 2'd0);
  assign out_data  = buf_data[0];
  assign out_last  = out_valid && buf_last[0];
  assign pop       = out_valid && out_ready;

  // Reads are issued only if the word in the RAM register plus the buffer
  // contents still fit after this cycle's drain, so the buffer never overflows.
  assign occ    = {1'b0, buf_cnt} + {2'b0, q_vld} - {2'b0, pop};
  assign wr_idx = buf_cnt - {1'b0, pop};
  assign issue  = (state == UNLOAD) && (ptr != len) && (occ <= 3'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      len         <= '0;
      ptr         <= '0;
      cmd_err     <= 1'b0;
      q_vld       <= 1'b0;
      q_last      <= 1'b0;
      buf_cnt     <= 2'd0;
      buf_last    <= 2'b00;
      buf_data[0] <= '0;
      buf_data[1] <= '0;
    end else begin
      cmd_err <= 1'b0;
      q_vld   <= issue;
      q_last  <= issue && ptr_at_end;
      case (state)
        IDLE: begin
          if (cmd_fire && cmd_op != 2'b11) begin
            if (!len_ok) begin
              cmd_err <= 1'b1;
            end else begin
              len <= cmd_len;
              ptr <= '0;
              case (cmd_op)
                2'b00:   state <= LOAD_A;
                2'b01:   state <= LOAD_B;
                default: state <= UNLOAD;
              endcase
            end
          end
        end
        LOAD_A, LOAD_B: begin
          if (in_beat) begin
            ptr <= ptr + LEN_ONE;
            if (ptr_at_end) state <= IDLE;
          end
        end
        UNLOAD: begin
          if (issue) ptr <= ptr + LEN_ONE;
          if (pop && buf_last[0]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (pop) begin
        buf_data[0] <= buf_data[1];
        buf_last[0] <= buf_last[1];
        buf_last[1] <= 1'b0;
      end
      if (q_vld) begin
        if (wr_idx[0]) begin
          buf_data[1] <= q_data;
          buf_last[1] <= q_last;
        end else begin
          buf_data[0] <= q_data;
          buf_last[0] <= q_last;
        end
      end
      buf_cnt <= buf_cnt + {1'b0, q_vld} - {1'b0, pop};
    end
  end

  // RAM arrays carry no reset so their contents survive rst_n.
  always_ff @(posedge clk) begin
    if (state == LOAD_A && in_beat) ram_a[ptr[ADDR_WIDTH-1:0]] <= in_data;
    if (state == LOAD_B && in_beat) ram_b[ptr[ADDR_WIDTH-1:0]] <= in_data;
    if (mm_write_en_c) ram_c[mm_addr_c] <= mm_data_c;
    q_data <= ram_c[ptr[ADDR_WIDTH-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mm_data_a    <= '0;
      mm_data_b    <= '0;
      c_wr_count   <= '0;
      conflict_err <= 1'b0;
    end else begin
      if (mm_read_en_a) mm_data_a <= ram_a[mm_addr_a];
      if (mm_read_en_b) mm_data_b <= ram_b[mm_addr_b];
      if (clear) begin
        c_wr_count   <= '0;
        conflict_err <= 1'b0;
      end else begin
        if (mm_write_en_c && c_wr_count != DEPTH) c_wr_count <= c_wr_count + LEN_ONE;
        if ((mm_read_en_a && state == LOAD_A) || (mm_read_en_b && state == LOAD_B) ||
            (mm_write_en_c && state == UNLOAD))
          conflict_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_matrix_buffer_responder.sv
// tb/tb_matrix_buffer_responder.sv - self-checking bench for matrix_buffer_responder
// A transaction-level model predicts every output each cycle; literals pin the model.
module tb_matrix_buffer_responder;
  localparam int DW = 16;
  localparam int AW = 10;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 0, cmd_ready, cmd_err;
  logic [1:0] cmd_op = 0;
  logic [AW:0] cmd_len = 0;
  logic in_valid = 0, in_ready;
  logic [DW-1:0] in_data = 0;
  logic out_valid, out_ready = 0, out_last;
  logic [DW-1:0] out_data;
  logic [AW-1:0] mm_addr_a = 0, mm_addr_b = 0, mm_addr_c = 0;
  logic mm_read_en_a = 0, mm_read_en_b = 0, mm_write_en_c = 0;
  logic [DW-1:0] mm_data_a, mm_data_b, mm_data_c = 0;
  logic [AW:0] c_wr_count;
  logic conflict_err;

  always #5 clk = ~clk;

  matrix_buffer_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_err(cmd_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .mm_addr_a(mm_addr_a), .mm_read_en_a(mm_read_en_a), .mm_data_a(mm_data_a),
    .mm_addr_b(mm_addr_b), .mm_read_en_b(mm_read_en_b), .mm_data_b(mm_data_b),
    .mm_addr_c(mm_addr_c), .mm_data_c(mm_data_c), .mm_write_en_c(mm_write_en_c),
    .c_wr_count(c_wr_count), .conflict_err(conflict_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: mode 0 idle, 1 load A, 2 load B, 3 unload
  logic [DW-1:0] mem_a [DEPTH];
  logic [DW-1:0] mem_b [DEPTH];
  logic [DW-1:0] mem_c [DEPTH];
  int mode = 0, len_m = 0, ptr_m = 0, since_acc = 0, exp_cnt = 0, valid_cycles = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] wq[$];
  logic exp_cmd_err = 0, exp_conf = 0;
  logic [DW-1:0] exp_mm_a = 0, exp_mm_b = 0, s_data = 0;
  logic s_valid = 0;
  bit gapfree = 0, model_on = 0;

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      mode = 0; exp_q.delete(); exp_cmd_err = 0; exp_conf = 0;
      exp_mm_a = 0; exp_mm_b = 0; exp_cnt = 0; s_valid = 0;
    end else begin
      if (mm_read_en_a) exp_mm_a = mem_a[mm_addr_a];
      if (mm_read_en_b) exp_mm_b = mem_b[mm_addr_b];
      if (mode == 0 && cmd_valid && cmd_op == 2'b11) begin
        exp_cnt = 0; exp_conf = 0;
      end else begin
        if (mm_write_en_c && exp_cnt < DEPTH) exp_cnt++;
        if ((mm_read_en_a && mode == 1) || (mm_read_en_b && mode == 2) || (mm_write_en_c && mode == 3))
          exp_conf = 1;
      end
      if (mm_write_en_c) mem_c[mm_addr_c] = mm_data_c;
      exp_cmd_err = 0;
      case (mode)
        0: if (cmd_valid && cmd_op != 2'b11) begin
             if (cmd_len == 0 || int'(cmd_len) > DEPTH) exp_cmd_err = 1;
             else begin
               mode = int'(cmd_op) + 1; len_m = int'(cmd_len); ptr_m = 0; since_acc = 0;
               if (cmd_op == 2'b10) for (int i = 0; i < len_m; i++) exp_q.push_back(mem_c[i]);
             end
           end
        1, 2: if (in_valid) begin
             if (mode == 1) mem_a[ptr_m] = in_data; else mem_b[ptr_m] = in_data;
             ptr_m++;
             if (ptr_m == len_m) mode = 0;
           end
        default: begin
          since_acc++;
          if (s_valid && out_ready) begin
            got_q.push_back(s_data);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (exp_q.size() == 0) mode = 0;
          end
        end
      endcase
    end
    #1;
    if (rst_n && model_on) begin
      chk("cmd_ready", cmd_ready, mode == 0);
      chk("in_ready", in_ready, mode == 1 || mode == 2);
      chk("cmd_err", cmd_err, exp_cmd_err);
      chk("mm_data_a", mm_data_a, exp_mm_a);
      chk("mm_data_b", mm_data_b, exp_mm_b);
      chk("c_wr_count", c_wr_count, exp_cnt);
      chk("conflict_err", conflict_err, exp_conf);
      if (mode != 3) chk("out_valid_idle", out_valid, 0);
      else begin
        if (since_acc < 2) chk("out_valid_early", out_valid, 0);
        else if (since_acc == 2 || gapfree) chk("out_valid_on", out_valid, 1);
        if (out_valid) begin
          valid_cycles++;
          chk("out_pending", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            chk("out_data", out_data, exp_q[0]);
            chk("out_last", out_last, exp_q.size() == 1);
          end
        end
      end
    end
    s_valid = out_valid;
    s_data  = out_data;
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic send_cmd(input logic [1:0] op, input int len);
    cmd_valid = 1; cmd_op = op; cmd_len = (AW+1)'(len);
    tick();
    cmd_valid = 0;
  endtask

  task automatic load(input logic [1:0] op, input logic [DW-1:0] w[$]);
    send_cmd(op, w.size());
    foreach (w[i]) begin in_valid = 1; in_data = w[i]; tick(); end
    in_valid = 0;
  endtask

  task automatic unload(input int len, input bit stall);
    int cyc = 0;
    got_q.delete(); valid_cycles = 0; gapfree = !stall; out_ready = 1;
    send_cmd(2'b10, len);
    while (mode == 3 && cyc < 200) begin
      out_ready = !stall || (cyc % 3 == 0);
      tick(); cyc++;
    end
    chk("unload_finished", mode, 0);
    out_ready = 0; gapfree = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_cmd_err", cmd_err, 0);
    chk("rst_mm_data_a", mm_data_a, 0);
    chk("rst_mm_data_b", mm_data_b, 0);
    chk("rst_c_wr_count", c_wr_count, 0);
    chk("rst_conflict", conflict_err, 0);
    rst_n = 1; model_on = 1;
    tick();

    wq = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    load(2'b00, wq);
    mm_read_en_a = 1; mm_addr_a = 2; tick();
    chk("rd_a2", mm_data_a, 16'h0033);
    mm_addr_a = 0; tick();
    chk("rd_a0", mm_data_a, 16'h0011);
    mm_addr_a = 3; tick();
    chk("rd_a3", mm_data_a, 16'h0044);
    mm_read_en_a = 0; mm_addr_a = 1; tick();
    chk("rd_a_hold", mm_data_a, 16'h0044);

    for (int i = 0; i < 6; i++) begin
      mm_write_en_c = 1; mm_addr_c = AW'(i); mm_data_c = DW'(i * 3); tick();
    end
    mm_write_en_c = 0;
    chk("c_wr_count_6", c_wr_count, 6);
    unload(6, 1);
    chk("unload_stall_n", got_q.size(), 6);
    for (int i = 0; i < 6; i++) chk("unload_stall_word", got_q[i], i * 3);
    unload(6, 0);
    chk("unload_flow_n", got_q.size(), 6);
    chk("unload_flow_w5", got_q[5], 15);

    send_cmd(2'b00, 0);
    chk("rej0_err", cmd_err, 1);
    chk("rej0_ready", cmd_ready, 1);
    tick();
    chk("rej0_pulse", cmd_err, 0);
    send_cmd(2'b10, DEPTH + 1);
    chk("rejbig_err", cmd_err, 1);
    chk("rejbig_ready", cmd_ready, 1);
    tick();
    chk("rejbig_pulse", cmd_err, 0);

    wq.delete();
    for (int i = 0; i < DEPTH; i++) wq.push_back(DW'(i) ^ 16'hA5A5);
    load(2'b00, wq);
    chk("full_in_ready", in_ready, 0);
    chk("full_cmd_ready", cmd_ready, 1);
    mm_read_en_a = 1; mm_addr_a = AW'(DEPTH - 1); tick();
    chk("full_rd_last", mm_data_a, 16'hA65A);
    mm_read_en_a = 0;

    send_cmd(2'b01, 3);
    in_valid = 1; in_data = 16'h0B00; tick();
    in_data = 16'h0B01; tick();
    in_data = 16'h0B02; mm_read_en_b = 1; mm_addr_b = 0; tick();
    in_valid = 0; mm_read_en_b = 0;
    chk("conf_set", conflict_err, 1);
    chk("rd_b0", mm_data_b, 16'h0B00);
    tick();
    chk("conf_sticky", conflict_err, 1);
    mm_write_en_c = 1; mm_addr_c = 100; mm_data_c = 16'h1234;
    send_cmd(2'b11, 0);
    mm_write_en_c = 0;
    chk("clr_conf", conflict_err, 0);
    chk("clr_cnt", c_wr_count, 0);

    send_cmd(2'b00, 5);
    in_valid = 1; in_data = 16'hBEE0; tick();
    in_data = 16'hBEE1; tick();
    rst_n = 0; in_valid = 0;
    #1;
    chk("abort_in_ready", in_ready, 0);
    tick(); tick();
    rst_n = 1;
    tick();
    chk("abort_cmd_ready", cmd_ready, 1);
    mm_read_en_a = 1; mm_addr_a = 0; tick();
    chk("abort_rd0", mm_data_a, 16'hBEE0);
    mm_addr_a = 1; tick();
    chk("abort_rd1", mm_data_a, 16'hBEE1);
    mm_read_en_a = 0;

    unload(1, 0);
    chk("len1_n", got_q.size(), 1);
    chk("len1_word", got_q[0], 0);
    chk("len1_valid_cycles", valid_cycles, 1);
    tick();
    chk("len1_idle", cmd_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end
endmodule
